regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the integer datapath, with a per-register pending scoreboard. It provides N_READ combinational read ports and two prioritised write ports. Optional write-to-read bypass and a reserve port let the issue stage mark a destination register busy until its result is written back. Register 0 is hard-wired to zero.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- NUM_REGS, 32, register count; power of two, ≥ 2
- N_READ, 2, number of read ports (1–4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return pre-edge contents

Ports (AW = clog2(NUM_REGS)):
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  N_READ*AW  packed read addresses; port i at [i*AW +: AW]
- rd_data  out  N_READ*DATA_W  packed read data
- rd_ready  out  N_READ  1 = addressed register is not pending (value final)
- wr_en  in  2  write enables; port 0 has priority
- wr_addr  in  2*AW  packed write addresses
- wr_data  in  2*DATA_W  packed write data
- rsv_en  in  1  reserve request: set pending bit of rsv_addr
- rsv_addr  in  AW  register to reserve
- pending  out  NUM_REGS  registered scoreboard vector, bit r = register r pending

## Operation
- Reset (rst_n low, asynchronous): all registers 0, pending all 0. rd_data reflects zeros immediately, rd_ready all 1.
- Write: on the rising edge, for each p with wr_en[p] and wr_addr[p] ≠ 0, registers[wr_addr[p]] ← wr_data[p], and pending[wr_addr[p]] is cleared.
- Dual write, same address: port 0 data is stored and port 1 is dropped. The pending bit is cleared once.
- Reserve: rsv_en with rsv_addr ≠ 0 sets pending[rsv_addr]. Reserving an already-pending register is legal; the bit stays set.
- Reserve and write to the same address in the same cycle: reserve wins, so pending ends at 1 and the data is still stored (a new producer supersedes the old one).
- Register 0: writes and reserves are ignored. pending[0] is always 0, and reads of address 0 return 0 with rd_ready = 1 for every BYPASS setting.
- Read, BYPASS = 1: if any enabled write port targets rd_addr (≠ 0) this cycle, rd_data takes that port's wr_data (port 0 if both match) and rd_ready = 1. Otherwise rd_data = the stored value and rd_ready = ~pending[addr], unless a same-cycle rsv_en targets that address, in which case it is still ready this cycle.
- Read, BYPASS = 0: rd_data = the stored value and rd_ready = ~pending[addr]. Same-cycle writes are not visible.
- All read ports are independent. Any number of ports may read the same address.

## Timing
- Reads are combinational from rd_addr, with zero latency.
- Write-to-read latency: 0 cycles with BYPASS = 1, 1 cycle with BYPASS = 0.
- Reserve to pending visible: 1 cycle (registered). Write-back to pending clear: 1 cycle. With BYPASS = 1, rd_ready also rises combinationally in the write cycle.
- Reset assertion takes effect mid-cycle without waiting for clk. The first update after deassertion happens on the next rising edge.
- There is no handshake or backpressure. Every write and reserve presented at an edge is accepted.

## Structure
- Package regfile_pkg holds:
  - the addr_w(NUM_REGS) function;
  - the ZERO_REG constant (0);
  - the WR_PORTS = 2 constant.
- Sub-module regfile_scoreboard holds the pending vector with its set/clear priority logic and rsv/write inputs. It is instantiated once.
- The data array and the bypass muxes live in regfile_mp.

## Test plan
- Reset then read: pulse rst_n low mid-cycle. Every rd_data reads 0, every rd_ready reads 1, and pending = 0 before the next clk edge.
- Write/read and x0:
  - wr_en[0] = 1, addr 5, data 0xDEAD_BEEF. The same-cycle read of 5 returns 0xDEAD_BEEF with BYPASS = 1; with BYPASS = 0 it returns 0 and then 0xDEAD_BEEF next cycle.
  - Writing 0x1234 to addr 0 still reads 0.
- Dual-write collision: both ports write addr 7, port 0 = 0x11 and port 1 = 0x22. The read after the edge is 0x11; the bypass read in the same cycle is also 0x11.
- Scoreboard lifecycle:
  - Reserve 9, then the next cycle: pending[9] = 1 and rd_ready = 0 on a port reading 9.
  - Write 9 with 0x55: with BYPASS = 1, rd_ready = 1 and data 0x55 in the same cycle; pending[9] = 0 after the edge.
- Reserve/write same cycle: pending[3] = 1; rsv_en on 3 together with a write of 0xAA to 3. After the edge, pending[3] = 1 and register 3 = 0xAA.
- Reset mid-operation: reserve 4 and write 0xFF to 6, then assert rst_n between edges. pending[4] = 0 and a read of 6 returns 0 immediately; post-reset writes behave normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
package regfile_pkg;

  localparam int ZERO_REG = 0;
  localparam int WR_PORTS = 2;

  // Address width for a register count; never narrower than one bit.
  function automatic int addr_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: write-back clears a register's bit, a reservation sets it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WR_PORTS-1:0]      wr_en_i,
  input  logic [WR_PORTS*AW-1:0]   wr_addr_i,
  input  logic                     rsv_en_i,
  input  logic [AW-1:0]            rsv_addr_i,
  output logic [NUM_REGS-1:0]      pending_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Clears are applied first so a same-cycle reservation (a newer producer) wins.
  always_comb begin
    pending_d = pending_q;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] != AW'(ZERO_REG))) begin
        pending_d[wr_addr_i[p*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en_i && (rsv_addr_i != AW'(ZERO_REG))) begin
      pending_d[rsv_addr_i] = 1'b1;
    end
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with two prioritised write ports, optional
// write-to-read bypass and a pending scoreboard; register 0 reads as zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = 64,
  parameter  int NUM_REGS = 32,
  parameter  int N_READ   = 2,
  parameter  int BYPASS   = 1,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_READ*AW-1:0]         rd_addr,
  output logic [N_READ*DATA_W-1:0]     rd_data,
  output logic [N_READ-1:0]            rd_ready,
  input  logic [WR_PORTS-1:0]          wr_en,
  input  logic [WR_PORTS*AW-1:0]       wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  output logic [NUM_REGS-1:0]          pending
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [AW-1:0]     ra;

  // Port 1 is written first so that port 0's assignment wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int p = WR_PORTS - 1; p >= 0; p--) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] != AW'(ZERO_REG))) begin
          regs_q[wr_addr[p*AW +: AW]] <= wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .pending_o  (pending)
  );

  // A same-cycle reservation does not affect readiness; it shows up next cycle.
  always_comb begin
    rd_data  = '0;
    rd_ready = '1;
    ra       = '0;
    for (int i = 0; i < N_READ; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (ra != AW'(ZERO_REG)) begin
        rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
        rd_ready[i]                 = ~pending[ra];
        if (BYPASS != 0) begin
          for (int p = WR_PORTS - 1; p >= 0; p--) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] == ra)) begin
              rd_data[i*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
              rd_ready[i]                 = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass and non-bypass instances share stimulus
// and are checked every cycle against an array model plus literal expectations.
module tb_regfile_mp;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NRD = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NRD*AW-1:0]    rd_addr;
  logic [1:0]           wr_en;
  logic [2*AW-1:0]      wr_addr;
  logic [2*DW-1:0]      wr_data;
  logic                 rsv_en;
  logic [AW-1:0]        rsv_addr;
  logic [NRD*DW-1:0]    rd_data_b, rd_data_n;
  logic [NRD-1:0]       rd_ready_b, rd_ready_n;
  logic [NR-1:0]        pending_b, pending_n;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 0;

  logic [DW-1:0] m_regs [NR];
  bit            m_pend [NR];

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .N_READ(NRD), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_ready(rd_ready_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(pending_b)
  );

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .N_READ(NRD), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_ready(rd_ready_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pending(pending_n)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model
  task automatic model_clear();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  function automatic logic [NR-1:0] model_pend_vec();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = m_pend[r];
    return v;
  endfunction

  task automatic model_read(input bit bp, input logic [AW-1:0] a,
                            output logic [DW-1:0] d, output logic rdy);
    logic [AW-1:0] a0, a1;
    a0 = wr_addr[AW-1:0];
    a1 = wr_addr[2*AW-1:AW];
    if (a == 0) begin
      d = '0; rdy = 1'b1;
    end else if (bp && wr_en[0] && a0 == a) begin
      d = wr_data[DW-1:0]; rdy = 1'b1;
    end else if (bp && wr_en[1] && a1 == a) begin
      d = wr_data[2*DW-1:DW]; rdy = 1'b1;
    end else begin
      d = m_regs[a]; rdy = !m_pend[a];
    end
  endtask

  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    logic [AW-1:0] a0, a1;
    if (rst_n === 1'b1) begin
      a0 = wr_addr[AW-1:0];
      a1 = wr_addr[2*AW-1:AW];
      if (wr_en[1] && a1 != 0 && !(wr_en[0] && a0 == a1)) begin
        m_regs[a1] = wr_data[2*DW-1:DW];
      end
      if (wr_en[0] && a0 != 0) m_regs[a0] = wr_data[DW-1:0];
      if (wr_en[0] && a0 != 0) m_pend[a0] = 1'b0;
      if (wr_en[1] && a1 != 0) m_pend[a1] = 1'b0;
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
  end

  // Scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    logic [DW-1:0] ed;
    logic          er;
    if (checking && rst_n === 1'b1) begin
      for (int p = 0; p < NRD; p++) begin
        model_read(1'b1, rd_addr[p*AW +: AW], ed, er);
        check($sformatf("cmp_b_data%0d", p), rd_data_b[p*DW +: DW], ed);
        check($sformatf("cmp_b_rdy%0d", p), DW'(rd_ready_b[p]), DW'(er));
        model_read(1'b0, rd_addr[p*AW +: AW], ed, er);
        check($sformatf("cmp_n_data%0d", p), rd_data_n[p*DW +: DW], ed);
        check($sformatf("cmp_n_rdy%0d", p), DW'(rd_ready_n[p]), DW'(er));
      end
      check("cmp_b_pending", DW'(pending_b), DW'(model_pend_vec()));
      check("cmp_n_pending", DW'(pending_n), DW'(model_pend_vec()));
    end
  end

  // Driver tasks
  task automatic clr_inputs();
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*DW +: DW] = d;
  endtask

  task automatic set_rsv(input logic [AW-1:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr_inputs();
  endtask

  task automatic check_reset_view(input string tag);
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("%s_b_data%0d", tag, p), rd_data_b[p*DW +: DW], '0);
      check($sformatf("%s_n_data%0d", tag, p), rd_data_n[p*DW +: DW], '0);
    end
    check({tag, "_b_rdy"}, DW'(rd_ready_b), DW'(2'b11));
    check({tag, "_n_rdy"}, DW'(rd_ready_n), DW'(2'b11));
    check({tag, "_b_pend"}, DW'(pending_b), '0);
    check({tag, "_n_pend"}, DW'(pending_n), '0);
  endtask

  initial begin
    rst_n = 1'b1;
    clr_inputs();
    model_clear();
    set_rd(0, 5'd5); set_rd(1, 5'd31);
    // Reset asserted between edges: zeros visible before any clock edge
    #3 rst_n = 1'b0;
    #1 check_reset_view("reset");
    #3 rst_n = 1'b1;
    checking = 1'b1;

    // Write 5, bypass vs. registered visibility
    tick(); set_wr(0, 5'd5, 64'hDEAD_BEEF); set_rd(0, 5'd5);
    #2;
    check("wr5_bypass", rd_data_b[DW-1:0], 64'hDEAD_BEEF);
    check("wr5_nobypass", rd_data_n[DW-1:0], 64'h0);
    tick(); set_rd(0, 5'd5);
    #2;
    check("wr5_next_nb", rd_data_n[DW-1:0], 64'hDEAD_BEEF);

    // Register 0 ignores writes
    tick(); set_wr(0, 5'd0, 64'h1234); set_rd(1, 5'd0);
    #2;
    check("x0_bypass", rd_data_b[2*DW-1:DW], 64'h0);
    check("x0_ready", DW'(rd_ready_b[1]), 64'h1);
    tick(); set_rd(1, 5'd0);
    #2;
    check("x0_after", rd_data_n[2*DW-1:DW], 64'h0);

    // Dual-write collision: port 0 wins
    tick(); set_wr(0, 5'd7, 64'h11); set_wr(1, 5'd7, 64'h22); set_rd(0, 5'd7);
    #2;
    check("dual_bypass", rd_data_b[DW-1:0], 64'h11);
    tick(); set_rd(0, 5'd7); set_rd(1, 5'd7);
    #2;
    check("dual_after_b", rd_data_b[2*DW-1:DW], 64'h11);
    check("dual_after_n", rd_data_n[DW-1:0], 64'h11);

    // Scoreboard lifecycle on 9
    tick(); set_rsv(5'd9); set_rd(1, 5'd9);
    #2;
    check("rsv9_same_cycle_rdy", DW'(rd_ready_b[1]), 64'h1);
    tick(); set_rd(1, 5'd9);
    #2;
    check("rsv9_pending", DW'(pending_b[9]), 64'h1);
    check("rsv9_rdy_b", DW'(rd_ready_b[1]), 64'h0);
    check("rsv9_rdy_n", DW'(rd_ready_n[1]), 64'h0);
    tick(); set_wr(1, 5'd9, 64'h55); set_rd(1, 5'd9);
    #2;
    check("wb9_rdy_b", DW'(rd_ready_b[1]), 64'h1);
    check("wb9_data_b", rd_data_b[2*DW-1:DW], 64'h55);
    check("wb9_rdy_n", DW'(rd_ready_n[1]), 64'h0);
    tick(); set_rd(1, 5'd9);
    #2;
    check("wb9_pend_clear", DW'(pending_n[9]), 64'h0);
    check("wb9_data_n", rd_data_n[2*DW-1:DW], 64'h55);

    // Reserve and write the same register in one cycle: reserve wins
    tick(); set_rsv(5'd3);
    tick(); set_rsv(5'd3); set_wr(0, 5'd3, 64'hAA);
    tick(); set_rd(0, 5'd3);
    #2;
    check("rsvwr3_pend", DW'(pending_b[3]), 64'h1);
    check("rsvwr3_data", rd_data_n[DW-1:0], 64'hAA);
    check("rsvwr3_rdy", DW'(rd_ready_n[0]), 64'h0);

    // Short stress over a narrow address range to force collisions
    for (int c = 0; c < 60; c++) begin
      tick();
      wr_en = 2'($urandom_range(0, 3));
      wr_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data = {32'h0, 32'($urandom), 32'h0, 32'($urandom)};
      rsv_en = 1'($urandom_range(0, 1));
      rsv_addr = 5'($urandom_range(0, 7));
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    end

    // Reset in the middle of activity
    tick(); set_rsv(5'd4); set_wr(0, 5'd6, 64'hFF);
    tick(); set_rd(0, 5'd6);
    #2;
    check("mid_pend4_set", DW'(pending_b[4]), 64'h1);
    check("mid_reg6", rd_data_n[DW-1:0], 64'hFF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pend4", DW'(pending_b[4]), 64'h0);
    check("mid_rst_reg6_b", rd_data_b[DW-1:0], 64'h0);
    check("mid_rst_reg6_n", rd_data_n[DW-1:0], 64'h0);
    check("mid_rst_rdy", DW'(rd_ready_n[0]), 64'h1);
    #1 rst_n = 1'b1;
    tick(); set_wr(1, 5'd6, 64'h77); set_rd(0, 5'd6);
    #2;
    check("post_rst_bypass", rd_data_b[DW-1:0], 64'h77);
    tick(); set_rd(0, 5'd6);
    #2;
    check("post_rst_reg6", rd_data_n[DW-1:0], 64'h77);
    tick();
    tick();

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
